// File: rtl/pool_pkg.sv
// Shared types and default sizing for the 2x2 max-pool sequencer.
// FSM state encoding plus the pixel width, frame width and dimension-field width defaults.
// Holds no logic of its own.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    localparam int M_DEF     = 16;
    localparam int MAX_W_DEF = 64;

    // A dimension field must hold the frame width itself, not just width-1.
    function automatic int dim_width(input int max_w);
        return $clog2(max_w + 1);
    endfunction

    localparam int DIMW_DEF = dim_width(MAX_W_DEF);

endpackage

// File: rtl/pool_linebuf.sv
// Even-row pair-maximum store: DEPTH x M registers, indexed by pair number.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none, one write and one read per cycle.
module pool_linebuf #(
    parameter int M     = 16,
    parameter int DEPTH = 32,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [M-1:0]  wr_dat,
    input  logic [IW-1:0] rd_idx,
    output logic [M-1:0]  rd_dat
);

    // Contents are deliberately left unreset; every entry is written on an
    // even row before any odd row reads it.
    logic [M-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/pool2x2_ctrl.sv
// 2x2/stride-2 max-pool sequencer for one channel; optional POOL_PERF_EN adds stall_cnt.
// Latency: odd-row pair's second pixel accepted at t -> out_valid from t+2; 1 pixel/cycle.
// Backpressure: in_ready drops only at an odd-row pair's second pixel while out_valid is stalled.
module pool2x2_ctrl
    import pool_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int MAX_W = MAX_W_DEF,
    parameter int DIMW  = DIMW_DEF
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic            start,
    input  logic [DIMW-1:0] cfg_w,
    input  logic [DIMW-1:0] cfg_h,
    output logic            busy,
    output logic            done,
    input  logic [M-1:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [M-1:0]    ml_din,
    output logic            ml_valid_in,
    input  logic [M-1:0]    ml_result,
    input  logic            ml_valid_out,
    output logic [M-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready
`ifdef POOL_PERF_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int PW = $clog2(MAX_W / 2);

    pool_state_t     state_q, state_d;
    logic            drain_q, drain_d;
    logic [DIMW-1:0] col_q, col_d;
    logic [DIMW-1:0] row_q, row_d;
    logic [DIMW-1:0] w_q, w_d;
    logic [DIMW-1:0] h_q, h_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   pend_p_q, pend_p_d;
    logic            pend_odd_q, pend_odd_d;
    logic [M-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic            last_col;
    logic            last_row;
    logic            drop;
    logic            lb_we;
    logic [M-1:0]    lb_rd;
    logic [M-1:0]    pooled;

    assign last_col = (col_q == w_q - DIMW'(1));
    assign last_row = (row_q == h_q - DIMW'(1));

    // The unpaired trailing column/row is withheld so maxline always sees even counts.
    assign drop = (w_q[0] && last_col) || (h_q[0] && last_row);

    assign in_ready    = (state_q == RUN) &&
                         !(row_q[0] && col_q[0] && out_valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign ml_valid_in = accept && !drop;
    assign ml_din      = ml_valid_in ? in_data : '0;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        col_d   = col_q;
        row_d   = row_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = cfg_w;
                    h_d     = cfg_h;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (cfg_w == '0 || cfg_h == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIMW'(1);
                        if (last_row) begin
                            state_d = DRAIN;
                            drain_d = 1'b0;
                        end
                    end else begin
                        col_d = col_q + DIMW'(1);
                    end
                end
            end
            DRAIN: begin
                // Two cycles let the final maxline result land in out_data.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // maxline answers one cycle after the pair's second pixel, after the
    // counters have moved on, so the pair slot and row parity are captured here.
    assign lb_we  = ml_valid_out && !pend_odd_q;
    assign pooled = (lb_rd > ml_result) ? lb_rd : ml_result;

    always_comb begin
        pend_p_d    = pend_p_q;
        pend_odd_d  = pend_odd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        if (ml_valid_in) begin
            pend_p_d   = col_q[PW:1];
            pend_odd_d = row_q[0];
        end
        if (ml_valid_out && pend_odd_q) begin
            out_data_d  = pooled;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_p_q    <= '0;
            pend_odd_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            col_q       <= col_d;
            row_q       <= row_d;
            w_q         <= w_d;
            h_q         <= h_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_p_q    <= pend_p_d;
            pend_odd_q  <= pend_odd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    pool_linebuf #(
        .M     (M),
        .DEPTH (MAX_W / 2),
        .IW    (PW)
    ) u_linebuf (
        .clk    (clk),
        .wr_en  (lb_we),
        .wr_idx (pend_p_q),
        .wr_dat (ml_result),
        .rd_idx (pend_p_q),
        .rd_dat (lb_rd)
    );

`ifdef POOL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && in_valid && !in_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pool2x2_ctrl.md
# pool2x2_ctrl

2×2/stride-2 max-pool sequencer for one feature-map channel. It accepts a raster pixel stream, feeds horizontal pixel pairs to an external `maxline` stage, and holds even-row pair maxima in a line buffer. On odd rows it combines each `maxline` result with the stored value and emits the pooled pixel. It sits between the conv output stream and the pooled-map writer, one instance per channel lane.

## Interface
- `M`, 16: pixel data width (unsigned)
- `MAX_W`, 64: maximum frame width; line-buffer depth is MAX_W/2
- `DIMW`, 7: width of dimension fields, ≥ $clog2(MAX_W+1)
- `clk`  in  1  clock
- `Rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle frame start; sampled only in IDLE
- `cfg_w`, `cfg_h`  in  DIMW  frame width/height, latched on `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame end
- `in_data`  in  M  input pixel
- `in_valid` / `in_ready`  in/out  1  input handshake; transfer when both are high
- `ml_din`  out  M  pixel to `maxline`
- `ml_valid_in`  out  1  valid to `maxline`
- `ml_result`  in  M  `maxline` pair maximum
- `ml_valid_out`  in  1  `maxline` result valid; arrives 1 cycle after the second pixel of a pair
- `out_data`  out  M  pooled pixel, registered
- `out_valid` / `out_ready`  out/in  1  output handshake

## Operation
- FSM states and transitions:
  - IDLE→RUN on `start`, with `cfg_w`, `cfg_h` ≥ 1.
  - IDLE→DONE on `start` when `cfg_w`=0 or `cfg_h`=0.
  - RUN→DRAIN when the last pixel (row H-1, col W-1) is accepted.
  - DRAIN→DONE after 2 cycles.
  - DONE→IDLE unconditionally.
- `start` outside IDLE is ignored.
- Counters `col` and `row` advance on each accepted pixel. `col` wraps at W-1, then `row` increments.
- `ml_din` = `in_data` and `ml_valid_in` = accepted pixel, except the pixel is dropped (`ml_valid_in`=0) when:
  - W is odd and col = W-1, or
  - H is odd and row = H-1.
- This keeps `maxline` pair parity aligned: it always receives an even count per row.
- Pair index `p` = col>>1.
- Even row, `ml_valid_out`: `linebuf[p]` ← `ml_result`.
- Odd row, `ml_valid_out`: `out_data` ← max(`linebuf[p]`, `ml_result`) using an unsigned compare; on a tie the `ml_result` value is taken. `out_valid` ← 1.
- `out_valid` clears on `out_ready` unless a new result loads in the same cycle.
- `in_ready` = (state==RUN) && !(row odd && col odd && `out_valid` && !`out_ready`). Backpressure applies only at the second pixel of an odd-row pair.
- W<2 or H<2: all pixels are consumed, no output is produced, and `done` still pulses.

## Timing
- Reset values: state IDLE; `busy`, `done`, `in_ready`, `ml_valid_in`, `out_valid` = 0; `out_data`, `ml_din` = 0. Counters are cleared.
- Line-buffer contents are not reset.
- Latency: second pixel of an odd-row pair accepted at cycle t → `maxline` result in t+1 → `out_valid` high from t+2.
- Full throughput of 1 pixel/cycle while `out_ready` stays high.
- The last `out_valid` may remain pending after `done`; it is held until `out_ready`.
- `Rst_n` asserted mid-frame: the block returns to IDLE immediately with no `done`. `maxline` shares `Rst_n`, so its pair parity realigns.

## Configuration
- `POOL_PERF_EN` defined: adds output `stall_cnt` [15:0]. It counts RUN cycles with `in_valid` && !`in_ready`, clears on `start`, and saturates at 0xFFFF.
- `POOL_PERF_EN` undefined: the port and counter are absent.

## Structure
- The shared package `pool_pkg` holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE),
  - the default `M` / `MAX_W` constants,
  - the `DIMW` derivation.
- One sub-module, `pool_linebuf`: MAX_W/2 × M register array with a synchronous write port and an asynchronous read port, indexed by pair.

## Test plan
- 4×4 frame, pixel = 4r+c, `out_ready`=1 → outputs 5, 7, 13, 15; `done` pulses once; no `in_ready` drops.
- W=5, H=3, pixel = 5r+c → outputs 6, 8 only. Column 4 and row 2 never assert `ml_valid_in`.
- 4×2 frame with row 0 = 100, row 1 = 1 → outputs 100, 100 (stored even-row value wins).
- 8×2 frame with `out_ready` held low for 10 cycles after the first output → `in_ready` drops only at the odd-row pair boundary; all 4 outputs are delivered in order, with no loss or duplication.
- `start` with `cfg_w`=0 → `done` pulses 1 cycle after IDLE→DONE with zero input transfers. Reset asserted mid-4×4 frame, then a clean frame → the clean frame produces the correct 4 outputs.
- With `POOL_PERF_EN` defined, the 8×2 backpressure case → `stall_cnt` equals the observed `in_valid` && !`in_ready` cycle count.
